// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolution allocator slice.
// Imported by the allocator top and its MAC pipeline.
package conv_pkg;

  localparam int DATA_W    = 18;
  localparam int ACC_W     = 48;
  localparam int WADDR_W   = 14;
  localparam int COORD_W   = 8;
  localparam int DEPTH_W   = 9;
  localparam int TAP_CNT_W = 14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_DONE
  } state_t;

endpackage

// File: rtl/conv_allocator_mac.sv
// Multiply-accumulate pipeline: aligns pixel with weight RAM latency,
// registers the product, accumulates and counts taps.
module conv_allocator_mac #(
  parameter int DATA_W = 18,
  parameter int ACC_W  = 48,
  parameter int CNT_W  = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [DATA_W-1:0] weight,
  input  logic [CNT_W-1:0]         n_taps,
  output logic signed [ACC_W-1:0]  acc_next,
  output logic                     done
);

  logic                       p_valid;
  logic signed [DATA_W-1:0]   p_data;
  logic                       m_valid;
  logic signed [2*DATA_W-1:0] m_prod;
  logic signed [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]           cnt;

  assign acc_next = acc + ACC_W'(m_prod);
  assign done     = m_valid && (cnt + CNT_W'(1) == n_taps);

  // pixel waits one cycle here while the weight read completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_data  <= '0;
      m_valid <= 1'b0;
      m_prod  <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else if (clear) begin
      p_valid <= 1'b0;
      p_data  <= '0;
      m_valid <= 1'b0;
      m_prod  <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      p_valid <= in_valid;
      p_data  <= in_data;
      m_valid <= p_valid;
      m_prod  <= p_data * weight;
      if (m_valid) begin
        acc <= acc_next;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/conv_allocator.sv
// Per-slot convolution allocator: window hit detect, weight addressing,
// centre/shadow control and result hand-off.
module conv_allocator #(
  parameter int DATA_W  = conv_pkg::DATA_W,
  parameter int ACC_W   = conv_pkg::ACC_W,
  parameter int WADDR_W = conv_pkg::WADDR_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [1:0]                        filter_halfsize,
  input  logic [conv_pkg::DEPTH_W-1:0]      image_depth,
  input  logic [conv_pkg::COORD_W-1:0]      position_x,
  input  logic [conv_pkg::COORD_W-1:0]      position_y,
  input  logic                              position_select,
  input  logic [conv_pkg::COORD_W-1:0]      issue_x,
  input  logic [conv_pkg::COORD_W-1:0]      issue_y,
  input  logic [conv_pkg::DEPTH_W-1:0]      issue_z,
  input  logic [DATA_W-1:0]                 issue_data,
  input  logic                              issue_en,
  output logic                              issue_block,
  output logic [WADDR_W-1:0]                weight_read_addr,
  input  logic [DATA_W-1:0]                 weight_read_data,
  output logic [conv_pkg::COORD_W-1:0]      result_x,
  output logic [conv_pkg::COORD_W-1:0]      result_y,
  output logic [ACC_W-1:0]                  result_data,
  output logic                              result_valid,
  input  logic                              result_ack
);

  import conv_pkg::*;

  state_t state, state_nx;

  logic [COORD_W-1:0] cx, cy, sh_x, sh_y;
  logic               sh_full;

  logic                     s0_valid;
  logic signed [DATA_W-1:0] s0_data;

  logic signed [COORD_W:0] dx, dy, hs;
  logic                    hit;
  logic [2:0]              side, ux, uy;
  logic [4:0]              tap;
  logic [14:0]             addr_sum;
  logic [TAP_CNT_W-1:0]    n_taps;

  logic signed [ACC_W-1:0] acc_next;
  logic                    mac_done;

  logic load_pos, load_sh, sh_set, sh_clr;
  logic clear, res_set, res_clr;

  // 9-bit signed deltas so a centre near the border cannot wrap
  assign hs  = {{(COORD_W-1){1'b0}}, filter_halfsize};
  assign dx  = {1'b0, issue_x} - {1'b0, cx};
  assign dy  = {1'b0, issue_y} - {1'b0, cy};
  assign hit = issue_en
            && (dx <= hs) && (dx >= -hs)
            && (dy <= hs) && (dy >= -hs);

  assign side     = {filter_halfsize, 1'b1};
  assign ux       = dx[2:0] + {1'b0, filter_halfsize};
  assign uy       = dy[2:0] + {1'b0, filter_halfsize};
  assign tap      = 5'(uy) * 5'(side) + 5'(ux);
  assign addr_sum = 15'(tap) * 15'(image_depth) + 15'(issue_z);
  assign n_taps   = TAP_CNT_W'(side) * TAP_CNT_W'(side)
                  * TAP_CNT_W'(image_depth);

  assign issue_block = sh_full && (state != ST_ACC);

  always_comb begin
    state_nx = state;
    load_pos = 1'b0;
    load_sh  = 1'b0;
    sh_set   = 1'b0;
    sh_clr   = 1'b0;
    clear    = 1'b0;
    res_set  = 1'b0;
    res_clr  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (position_select) begin
          load_pos = 1'b1;
          clear    = 1'b1;
          state_nx = ST_ACC;
        end
      end
      ST_ACC: begin
        sh_set = position_select;
        if (mac_done) begin
          res_set  = 1'b1;
          clear    = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        if (result_ack) begin
          res_clr = 1'b1;
          if (sh_full) begin
            load_sh  = 1'b1;
            sh_clr   = 1'b1;
            sh_set   = position_select;
            clear    = 1'b1;
            state_nx = ST_ACC;
          end else if (position_select) begin
            load_pos = 1'b1;
            clear    = 1'b1;
            state_nx = ST_ACC;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          sh_set = position_select;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      cx               <= '0;
      cy               <= '0;
      sh_x             <= '0;
      sh_y             <= '0;
      sh_full          <= 1'b0;
      s0_valid         <= 1'b0;
      s0_data          <= '0;
      weight_read_addr <= '0;
      result_x         <= '0;
      result_y         <= '0;
      result_data      <= '0;
      result_valid     <= 1'b0;
    end else begin
      state <= state_nx;
      if (load_pos) begin
        cx <= position_x;
        cy <= position_y;
      end else if (load_sh) begin
        cx <= sh_x;
        cy <= sh_y;
      end
      if (sh_set) begin
        sh_x    <= position_x;
        sh_y    <= position_y;
        sh_full <= 1'b1;
      end else if (sh_clr) begin
        sh_full <= 1'b0;
      end
      s0_valid <= (state == ST_ACC) && hit && !mac_done;
      if ((state == ST_ACC) && hit && !mac_done) begin
        s0_data          <= issue_data;
        weight_read_addr <= addr_sum[WADDR_W-1:0];
      end
      if (res_set) begin
        result_valid <= 1'b1;
        result_data  <= acc_next;
        result_x     <= cx;
        result_y     <= cy;
      end else if (res_clr) begin
        result_valid <= 1'b0;
      end
    end
  end

  conv_allocator_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .CNT_W  (TAP_CNT_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (s0_valid),
    .in_data  (s0_data),
    .weight   (weight_read_data),
    .n_taps   (n_taps),
    .acc_next (acc_next),
    .done     (mac_done)
  );

endmodule

// File: tb/tb_conv_allocator.sv
// Randomised scoreboard bench for conv_allocator with a
// window-sum reference model and a decoupled result monitor.
module tb_conv_allocator;

  import conv_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         filter_halfsize;
  logic [DEPTH_W-1:0] image_depth;
  logic [COORD_W-1:0] position_x, position_y;
  logic               position_select;
  logic [COORD_W-1:0] issue_x, issue_y;
  logic [DEPTH_W-1:0] issue_z;
  logic [DATA_W-1:0]  issue_data;
  logic               issue_en;
  logic               issue_block;
  logic [WADDR_W-1:0] weight_read_addr;
  logic [DATA_W-1:0]  weight_read_data;
  logic [COORD_W-1:0] result_x, result_y;
  logic [ACC_W-1:0]   result_data;
  logic               result_valid;
  logic               result_ack;

  conv_allocator dut (
    .clk              (clk),
    .rst              (rst),
    .filter_halfsize  (filter_halfsize),
    .image_depth      (image_depth),
    .position_x       (position_x),
    .position_y       (position_y),
    .position_select  (position_select),
    .issue_x          (issue_x),
    .issue_y          (issue_y),
    .issue_z          (issue_z),
    .issue_data       (issue_data),
    .issue_en         (issue_en),
    .issue_block      (issue_block),
    .weight_read_addr (weight_read_addr),
    .weight_read_data (weight_read_data),
    .result_x         (result_x),
    .result_y         (result_y),
    .result_data      (result_data),
    .result_valid     (result_valid),
    .result_ack       (result_ack)
  );

  always #5 clk = ~clk;

  logic signed [DATA_W-1:0] wmem [0:(1<<WADDR_W)-1];
  always @(posedge clk) weight_read_data <= wmem[weight_read_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     x;
    int     y;
    longint data;
    int     cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   passed = 0;
  int   total  = 0;
  bit   seen   = 1'b0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst || !result_valid) begin
      seen = 1'b0;
    end else if (!seen) begin
      seen = 1'b1;
      if (sb.size() == 0) begin
        chk("unexpected_result", longint'(result_valid), 0);
      end else begin
        mon_e = sb.pop_front();
        chk("res_x", longint'(result_x), longint'(mon_e.x));
        chk("res_y", longint'(result_y), longint'(mon_e.y));
        chk("res_data", longint'($signed(result_data)), mon_e.data);
        chk("res_latency", longint'(cyc), longint'(mon_e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sel(input int x, input int y);
    position_x      = 8'(x);
    position_y      = 8'(y);
    position_select = 1'b1;
    step();
    position_select = 1'b0;
  endtask

  task automatic set_layer(input int h, input int d);
    filter_halfsize = 2'(h);
    image_depth     = 9'(d);
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) wmem[i] = 18'($urandom);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_block"}, longint'(issue_block), 0);
    chk({tag, "_waddr"}, longint'(weight_read_addr), 0);
    chk({tag, "_rx"}, longint'(result_x), 0);
    chk({tag, "_ry"}, longint'(result_y), 0);
    chk({tag, "_rdata"}, longint'(result_data), 0);
    chk({tag, "_rvalid"}, longint'(result_valid), 0);
  endtask

  // raster scan of the window plus margin; model sums data*weight
  // for every pixel whose offset from the centre is within h
  task automatic run_stream(input int cx, input int cy, input int h,
                            input int d, input int margin,
                            input int gapmax, input bit drnd,
                            input int dval, input bit chk_addr,
                            input int limit);
    int     n, hits, cnt, g, dv, t, a;
    longint sum;
    n = (2*h+1) * (2*h+1) * d;
    hits = 0;
    cnt = 0;
    sum = 0;
    for (int y = cy-h-margin; y <= cy+h+margin; y++) begin
      for (int x = cx-h-margin; x <= cx+h+margin; x++) begin
        for (int z = 0; z < d; z++) begin
          if (x < 0 || x > 255 || y < 0 || y > 255) continue;
          if (limit >= 0 && cnt >= limit) return;
          g = $urandom_range(0, gapmax);
          repeat (g) begin
            issue_x  = 8'(cx);
            issue_y  = 8'(cy);
            issue_en = 1'b0;
            step();
          end
          g = 0;
          while (issue_block && g < 20) begin
            step();
            g++;
          end
          if (g >= 20) chk("block_timeout", longint'(issue_block), 0);
          dv = drnd ? ($urandom_range(0, 262143) - 131072) : dval;
          issue_x    = 8'(x);
          issue_y    = 8'(y);
          issue_z    = 9'(z);
          issue_data = 18'(dv);
          issue_en   = 1'b1;
          step();
          issue_en = 1'b0;
          cnt++;
          if ((x-cx) <= h && (cx-x) <= h && (y-cy) <= h && (cy-y) <= h) begin
            hits++;
            t = (y-cy+h) * (2*h+1) + (x-cx+h);
            a = (t*d + z) % (1 << WADDR_W);
            sum += longint'(dv) * longint'(wmem[a]);
            if (chk_addr) chk("waddr", longint'(weight_read_addr), longint'(a));
            if (hits == n) sb.push_back('{cx, cy, sum, cyc + 3});
          end
        end
      end
    end
  endtask

  task automatic wait_valid();
    int g = 0;
    while (!result_valid && g < 300) begin
      step();
      g++;
    end
    chk("result_arrives", longint'(result_valid), 1);
  endtask

  task automatic ack();
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
  endtask

  task automatic wait_ack(input int delay);
    wait_valid();
    repeat (delay) step();
    ack();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    int h, d, cx, cy;
    rst = 1'b1;
    position_x = '0;
    position_y = '0;
    position_select = 1'b0;
    issue_x = '0;
    issue_y = '0;
    issue_z = '0;
    issue_data = '0;
    issue_en = 1'b0;
    result_ack = 1'b0;
    set_layer(1, 1);
    for (int i = 0; i < (1 << WADDR_W); i++) wmem[i] = '0;
    repeat (2) step();
    check_outputs_zero("reset");
    rst = 1'b0;
    step();

    // 3x3 window, weights 1..9, data 1 over a 9x9 region
    for (int i = 0; i < 9; i++) wmem[i] = 18'(i + 1);
    set_layer(1, 1);
    sel(5, 5);
    run_stream(5, 5, 1, 1, 3, 0, 1'b0, 1, 1'b0, -1);
    wait_ack(0);

    // 5x5x3 window, weights -1, data 2, address sequence checked
    for (int i = 0; i < 75; i++) wmem[i] = -18'sd1;
    set_layer(2, 3);
    sel(2, 2);
    run_stream(2, 2, 2, 3, 1, 0, 1'b0, 2, 1'b1, -1);
    wait_ack(1);

    // single tap, full depth, random gaps; leave result pending
    fill_rand(384);
    set_layer(0, 384);
    sel(7, 3);
    run_stream(7, 3, 0, 384, 0, 3, 1'b1, 0, 1'b0, -1);
    wait_valid();

    // shadow centre while result pending
    sel(9, 9);
    chk("block_shadow", longint'(issue_block), 1);
    set_layer(1, 2);
    fill_rand(18);
    ack();
    chk("block_after_ack", longint'(issue_block), 0);
    chk("valid_after_ack", longint'(result_valid), 0);
    run_stream(9, 9, 1, 2, 1, 1, 1'b1, 0, 1'b0, -1);
    wait_valid();

    // ack and select in the same cycle
    position_x      = 8'(3);
    position_y      = 8'(1);
    position_select = 1'b1;
    result_ack      = 1'b1;
    step();
    position_select = 1'b0;
    result_ack      = 1'b0;
    chk("ack_sel_valid", longint'(result_valid), 0);
    chk("ack_sel_block", longint'(issue_block), 0);
    run_stream(3, 1, 1, 2, 1, 1, 1'b1, 0, 1'b0, -1);
    wait_ack(2);

    // async reset mid-accumulation
    sel(4, 4);
    run_stream(4, 4, 1, 2, 1, 0, 1'b1, 0, 1'b0, 14);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    step();
    rst = 1'b0;
    step();
    sel(4, 4);
    run_stream(4, 4, 1, 2, 1, 1, 1'b1, 0, 1'b0, -1);
    wait_ack(0);

    // randomised rounds
    for (int r = 0; r < 8; r++) begin
      h  = $urandom_range(0, 2);
      d  = $urandom_range(1, 5);
      cx = $urandom_range(h, 20);
      cy = $urandom_range(h, 20);
      fill_rand(25 * 5);
      set_layer(h, d);
      sel(cx, cy);
      run_stream(cx, cy, h, d, 1, 2, 1'b1, 0, 1'b0, -1);
      wait_ack($urandom_range(0, 3));
    end

    repeat (4) step();
    chk("scoreboard_drained", longint'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/conv_allocator.md
Name: conv_allocator

Overview:
- Per-DSP convolution accumulator sitting directly downstream of the issue stage; one instance per allocator slot, up to num_allocators instances.
- Latches a filter centre when selected by the positioner, then snoops the broadcast pixel stream.
- For each pixel inside its window it fetches the matching filter weight and multiply-accumulates.
- Presents one finished output pixel per positioning round on a valid/ack result port.

Parameters:
- DATA_W, 18, width of pixel and weight data (signed).
- ACC_W, 48, accumulator and result width (signed).
- WADDR_W, 14, weight memory address width (25 taps x 384 depth = 9600 max).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- filter_halfsize  in  2  0..2; window is (2h+1)x(2h+1); held stable per layer
- image_depth  in  9  1..384; held stable per layer
- position_x  in  8  centre x in padded coordinates (from positioner)
- position_y  in  8  centre y in padded coordinates
- position_select  in  1  this instance's select bit; 1-cycle pulse latches the centre
- issue_x  in  8  broadcast pixel x in padded coordinates
- issue_y  in  8  broadcast pixel y in padded coordinates
- issue_z  in  9  broadcast channel index
- issue_data  in  18  pixel value (padding pixels arrive as 0)
- issue_en  in  1  issue_x/y/z/data valid this cycle
- issue_block  out  1  stall request to issue
- weight_read_addr  out  WADDR_W  weight RAM address
- weight_read_data  in  DATA_W  weight RAM data, 1-cycle read latency
- result_x  out  8  centre x of finished result
- result_y  out  8  centre y of finished result
- result_data  out  ACC_W  convolution sum
- result_valid  out  1  result held until acked
- result_ack  in  1  consumer accepts the result on a cycle where result_valid=1

Behaviour:
- Reset values: issue_block=0, weight_read_addr=0, result_x=0, result_y=0, result_data=0, result_valid=0. Accumulator and counters are 0; state IDLE; shadow empty.
- Hit condition: issue_en && |issue_x-cx|<=h && |issue_y-cy|<=h. Compare with 9-bit arithmetic; no underflow at cx<h.
- Tap index: t = (issue_y-cy+h)*(2h+1) + (issue_x-cx+h).
- Weight address: weight_read_addr = t*image_depth + issue_z, truncated to WADDR_W.
- Pipeline:
  - S0: hit sampled; pixel and address registered.
  - S1: weight returns; signed DATA_W x DATA_W product registered.
  - S2: acc += product (sign-extended to ACC_W); tap counter increments.
- Expected taps: N = (2h+1)^2 * image_depth. Examples: h=0,d=1 gives 1; h=2,d=384 gives 9600.
- States:
  - IDLE: hits ignored. position_select latches cx,cy, clears acc and counter, goes to ACC.
  - ACC: hits feed the pipeline. When the counter reaches N at S2, the edge sets result_valid=1 with result_data=acc+product and result_x/y=cx/cy, and the state goes to DONE. Result latency is 3 edges after the final hit is sampled.
  - DONE: result held stable.
    - result_ack with shadow empty: clear result_valid, go to IDLE.
    - result_ack with shadow full: load the shadow centre, clear acc and counter, go to ACC next cycle.
- Shadow centre: position_select in DONE or ACC stores the centre in a one-entry shadow register and sets shadow full.
  - ACC finishing with shadow full: enter DONE, then follow the DONE rules.
  - Second select while shadow full: overwrites the shadow (upstream error).
- issue_block = shadow full && state != ACC. The issue stage never advances past a pixel this instance would miss.
- Block is combinational from registers, with no input-to-output path.
- Simultaneous events:
  - result_ack and position_select in DONE with shadow empty: the new centre is latched and the state goes to ACC.
  - Hits in flight in S0/S1 at the transition from ACC are discarded.
- Duplicate (x,y,z) issues are counted twice; upstream guarantees uniqueness.
- Async rst mid-operation: all state returns to reset values immediately; the in-flight pipeline is flushed.

Decomposition:
- Shared package conv_pkg:
  - Constants DATA_W, ACC_W, WADDR_W, COORD_W=8, DEPTH_W=9.
  - Allocator state encoding IDLE/ACC/DONE.
- One sub-module conv_allocator_mac: S1/S2 multiply-accumulate pipeline with clear, valid-in, and tap counter.
- Control FSM, window compare, and address generation stay in conv_allocator.

Test Plan:
- h=1, d=1, centre (5,5); issue full 9x9 region with data=1 and weights 1..9 → only 9 hits, result_data=45 3 edges after pixel (6,6), result_x/y=5/5.
- h=2, d=3, centre (2,2); issue the 5x5x3 window of data=2 with all weights=−1 → result_data=−150; weight_read_addr sequence matches t*3+z.
- Hit stream with issue_en gaps of 0–3 cycles, h=0, d=384 → result after exactly 384 hits; no extra taps counted.
- Result pending with no ack; new position_select (9,9) → issue_block=1. Ack → issue_block=0 the next cycle; accumulation restarts at centre (9,9).
- result_ack and position_select in the same cycle from DONE → result_valid=0; new centre latched; state ACC.
- Assert rst asynchronously mid-accumulation → all outputs 0 before the next clk edge; post-reset select restarts cleanly with the correct sum.
